// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter states, common keyboard command bytes
// and the odd-parity helper used when a byte is latched for transmission.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_XFER,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Parity bit that makes the total count of ones across data plus parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// One PS/2 line: two-flop synchroniser, stability filter and one-cycle edge pulses
// that fire in the same cycle the filtered level changes.
module ps2_host_tx_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  // A new level is accepted only after FILTER_CYCLES consecutive cycles of disagreement.
  always_comb begin
    sync_d = {sync_q[0], line_i};
    cnt_d  = '0;
    lvl_d  = lvl_q;
    fall_d = 1'b0;
    rise_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        lvl_d  = sync_q[1];
        fall_d = lvl_q;
        rise_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = lvl_q;
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/parity bits on
// device clock falls, checks the device ACK and reports done or err.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clk_i,
  input  logic       ps_dat_i,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e       state_q, state_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       nf_q, nf_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_level, clk_fall, clk_rise;
  logic dat_level, dat_fall, dat_rise;
  logic unused_edges;

  ps2_host_tx_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clock   (clock),
    .reset   (reset),
    .line_i  (ps_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall),
    .rise_o  (clk_rise)
  );

  ps2_host_tx_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
    .clock   (clock),
    .reset   (reset),
    .line_i  (ps_dat_i),
    .level_o (dat_level),
    .fall_o  (dat_fall),
    .rise_o  (dat_rise)
  );

  assign unused_edges = clk_rise ^ dat_fall ^ dat_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      shift_q  <= '0;
      nf_q     <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      shift_q  <= shift_d;
      nf_q     <= nf_d;
      inh_q    <= inh_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // The shift register holds {parity, data}; each device clock fall presents the next bit.
  always_comb begin
    state_d  = state_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    shift_d  = shift_q;
    nf_d     = nf_q;
    inh_d    = inh_q;
    tmo_d    = tmo_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d  = {odd_parity(data), data};
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          inh_d    = '0;
          nf_d     = '0;
          ack_d    = 1'b0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYCLES)) begin
          clk_oe_d = 1'b0;
          nf_d     = '0;
          tmo_d    = '0;
          state_d  = ST_XFER;
        end else begin
          inh_d = inh_q + INH_W'(1);
          if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
            dat_oe_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_fall) begin
          nf_d = nf_q + 4'd1;
          if (nf_q < 4'd9) begin
            dat_oe_d = ~shift_q[0];
            shift_d  = {1'b0, shift_q[8:1]};
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_fall) begin
          nf_d    = nf_q + 4'd1;
          ack_d   = ~dat_level;
          state_d = ST_WAITIDLE;
        end
      end
      ST_WAITIDLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (clk_level && dat_level) begin
          done_d   = ack_q;
          err_d    = ~ack_q;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    // A silent or stuck device aborts the frame from any post-release state.
    if ((state_q == ST_XFER || state_q == ST_ACK || state_q == ST_WAITIDLE) &&
        tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      done_d   = 1'b0;
      err_d    = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = ST_IDLE;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    ps_clk_oe = clk_oe_q;
    ps_dat_oe = dat_oe_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural PS/2 device that clocks
// frames in, ACKs or NACKs them, and records every bit it samples.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TMO = 1500;
  localparam int FLT = 8;
  localparam int H   = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       ps_clk_i;
  logic       ps_dat_i;
  logic       ps_clk_oe;
  logic       ps_dat_oe;
  logic       busy;
  logic       done;
  logic       err;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch      = 1'b0;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int done_fall_cnt = 0;
  logic prev_busy = 1'b0;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_CYCLES  (FLT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .ps_clk_i  (ps_clk_i),
    .ps_dat_i  (ps_dat_i),
    .ps_clk_oe (ps_clk_oe),
    .ps_dat_oe (ps_dat_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Open-drain bus: any driver pulling low wins, otherwise the pull-up gives 1.
  assign ps_clk_i = ~(ps_clk_oe | dev_clk_low | glitch);
  assign ps_dat_i = ~(ps_dat_oe | dev_dat_low);

  always #5 clock = ~clock;

  always @(negedge clock) begin
    prev_busy <= busy;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
    if (done && !busy && prev_busy) done_fall_cnt <= done_fall_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data = 8'h00;
    tick(3);
    checks++;
    if ({ps_clk_oe, ps_dat_oe, busy, done, err} !== 5'b0)
      $display("[TB] FAIL reset_hold outputs=%b expected=00000", {ps_clk_oe, ps_dat_oe, busy, done, err});
    else passed++;
    reset = 1'b0;
    tick(3);
    checks++;
    if ({ps_clk_oe, ps_dat_oe, busy, done, err} !== 5'b0)
      $display("[TB] FAIL reset_idle outputs=%b expected=00000", {ps_clk_oe, ps_dat_oe, busy, done, err});
    else passed++;
  endtask

  // One complete host frame against the device model; reset_at=k resets at the k-th fall.
  task automatic run_frame(input string name, input logic [7:0] d, input bit nack,
                           input bit glitch_on, input int reset_at);
    int n;
    int d0, e0, f0;
    logic [10:0] bits;
    logic exp_par;
    bit aborted;
    d0 = done_cnt; e0 = err_cnt; f0 = done_fall_cnt;
    aborted = 1'b0;
    bits = '0;
    exp_par = ($countones(d) % 2 == 0);
    start = 1'b1; data = d;
    tick(1);
    start = 1'b0; data = 8'($urandom);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL %s busy_on got=%b want=1", name, busy);
    else passed++;
    n = 0;
    while (ps_clk_oe === 1'b1 && ps_dat_oe === 1'b0 && n <= INH + 10) begin
      if (glitch_on && n == 5) begin start = 1'b1; data = ~d; end
      if (glitch_on && n == 6) start = 1'b0;
      n++;
      tick(1);
    end
    start = 1'b0;
    checks++;
    if (n != INH) $display("[TB] FAIL %s inhibit_len got=%0d want=%0d", name, n, INH);
    else passed++;
    checks++;
    if ({ps_clk_oe, ps_dat_oe} !== 2'b11) $display("[TB] FAIL %s start_bit_drive got=%b want=11", name, {ps_clk_oe, ps_dat_oe});
    else passed++;
    tick(1);
    checks++;
    if ({ps_clk_oe, ps_dat_oe} !== 2'b01) $display("[TB] FAIL %s clk_release got=%b want=01", name, {ps_clk_oe, ps_dat_oe});
    else passed++;
    tick(H);
    bits[0] = ps_dat_i;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      for (int c = 0; c < H; c++) begin
        if (k == reset_at && c == H / 2) begin
          aborted = 1'b1;
          break;
        end
        tick(1);
      end
      if (aborted) break;
      dev_clk_low = 1'b0;
      for (int c = 0; c < H; c++) begin
        if (k == 11 && c == 0) dev_dat_low = 1'b0;
        if (c == H / 2 && k <= 10) bits[k] = ps_dat_i;
        if (c == H / 2 && k == 10 && !nack) dev_dat_low = 1'b1;
        if (glitch_on && k >= 2 && k <= 9 && c == H / 2 + 2) glitch = 1'b1;
        if (c == H / 2 + 5) glitch = 1'b0;
        tick(1);
      end
    end
    if (aborted) begin
      reset = 1'b1;
      tick(1);
      checks++;
      if ({ps_clk_oe, ps_dat_oe, busy} !== 3'b000)
        $display("[TB] FAIL %s reset_release got=%b want=000", name, {ps_clk_oe, ps_dat_oe, busy});
      else passed++;
      reset = 1'b0;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      tick(20);
      checks++;
      if (done_cnt != d0 || err_cnt != e0)
        $display("[TB] FAIL %s reset_no_pulse done=%0d err=%0d want=0,0", name, done_cnt - d0, err_cnt - e0);
      else passed++;
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 4 * H) begin
        n++;
        tick(1);
      end
      tick(3);
      checks++;
      if (busy !== 1'b0) $display("[TB] FAIL %s busy_drop got=%b want=0", name, busy);
      else passed++;
      checks++;
      if (bits[0] !== 1'b0) $display("[TB] FAIL %s start_bit got=%b want=0", name, bits[0]);
      else passed++;
      checks++;
      if (bits[8:1] !== d) $display("[TB] FAIL %s data_bits got=%h want=%h", name, bits[8:1], d);
      else passed++;
      checks++;
      if (bits[9] !== exp_par) $display("[TB] FAIL %s parity got=%b want=%b", name, bits[9], exp_par);
      else passed++;
      checks++;
      if (bits[10] !== 1'b1) $display("[TB] FAIL %s stop_bit got=%b want=1", name, bits[10]);
      else passed++;
      checks++;
      if (done_cnt - d0 != (nack ? 0 : 1)) $display("[TB] FAIL %s done_count got=%0d want=%0d", name, done_cnt - d0, nack ? 0 : 1);
      else passed++;
      checks++;
      if (err_cnt - e0 != (nack ? 1 : 0)) $display("[TB] FAIL %s err_count got=%0d want=%0d", name, err_cnt - e0, nack ? 1 : 0);
      else passed++;
      if (!nack) begin
        checks++;
        if (done_fall_cnt - f0 != 1) $display("[TB] FAIL %s done_with_busy_fall got=%0d want=1", name, done_fall_cnt - f0);
        else passed++;
      end
      checks++;
      if ({ps_clk_oe, ps_dat_oe} !== 2'b00) $display("[TB] FAIL %s lines_released got=%b want=00", name, {ps_clk_oe, ps_dat_oe});
      else passed++;
      checks++;
      if (both_cnt != 0) $display("[TB] FAIL %s done_err_overlap got=%0d want=0", name, both_cnt);
      else passed++;
    end
  endtask

  task automatic test_enable_cmd();
    run_frame("enable_f4", 8'hF4, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame("set_leds_ed", 8'hED, 1'b0, 1'b0, 0);
    run_frame("led_arg_02", 8'h02, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_frame("random", 8'($urandom), 1'b0, 1'b0, 0);
  endtask

  task automatic test_nack();
    run_frame("nack", 8'($urandom), 1'b1, 1'b0, 0);
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    d0 = done_cnt;
    start = 1'b1; data = 8'($urandom);
    tick(1);
    start = 1'b0;
    n = 0;
    while (ps_clk_oe === 1'b1 && n <= INH + 20) begin
      n++;
      tick(1);
    end
    checks++;
    if (ps_clk_oe !== 1'b0) $display("[TB] FAIL tmo_clk_release got=%b want=0", ps_clk_oe);
    else passed++;
    n = 0;
    while (err !== 1'b1 && n <= TMO + 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != TMO) $display("[TB] FAIL tmo_latency got=%0d want=%0d", n, TMO);
    else passed++;
    checks++;
    if ({ps_clk_oe, ps_dat_oe, busy} !== 3'b000) $display("[TB] FAIL tmo_release got=%b want=000", {ps_clk_oe, ps_dat_oe, busy});
    else passed++;
    tick(3);
    checks++;
    if (done_cnt != d0) $display("[TB] FAIL tmo_no_done got=%0d want=0", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    run_frame("reset_at_nf5", 8'($urandom), 1'b0, 1'b0, 5);
    run_frame("after_reset", 8'($urandom), 1'b0, 1'b0, 0);
  endtask

  task automatic test_glitch_and_busy_start();
    run_frame("glitch_busy_start", 8'($urandom), 1'b0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_enable_cmd();
    test_back_to_back();
    test_random();
    test_nack();
    test_timeout();
    test_reset_mid_frame();
    test_glitch_and_busy_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
